// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding, owner ids and default widths
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LD = 1'b1;
  localparam int DEF_W = 16;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational winner selection between cpu and loader
module rr_pick2 #(
  parameter int CNT_W = 4,
  parameter int MAX_BURST = 8
) (
  input  logic             cpu_req,
  input  logic             ld_req,
  input  logic             owner,
  input  logic             ld_lock,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             grant_valid,
  output logic             grant_id
);
  // a lone requester wins; on a tie the loader keeps a locked burst, else round-robin
  always_comb begin
    grant_valid = cpu_req | ld_req;
    grant_id = (cpu_req & ld_req) ? ((owner & ld_lock & (burst_cnt < CNT_W'(MAX_BURST))) | ~owner) : ld_req;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between cpu and loader, one transaction at a time
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_W,
  parameter int ADDR_W = DEF_W,
  parameter int READ_LAT = 1,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int LW = READ_LAT > 1 ? $clog2(READ_LAT) : 1;
  state_t state;
  logic we_q;
  logic [BW-1:0] burst_cnt;
  logic [LW-1:0] lat_cnt;
  logic grant_valid, grant_id, sel_we;
  rr_pick2 #(.CNT_W(BW), .MAX_BURST(MAX_BURST)) u_pick (
    .cpu_req(cpu_req),
    .ld_req(ld_req),
    .owner(owner),
    .ld_lock(ld_lock),
    .burst_cnt(burst_cnt),
    .grant_valid(grant_valid),
    .grant_id(grant_id)
  );
  assign sel_we = grant_id ? ld_we : cpu_we;
  assign cpu_stall = cpu_req & ~cpu_ack;
  // transaction fsm: latch winner, strobe once, wait out the read latency, ack
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWNER_LD;
      burst_cnt <= '0;
      lat_cnt <= '0;
      we_q <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      cpu_ack <= 1'b0;
      ld_ack <= 1'b0;
      cpu_rdata <= '0;
      ld_rdata <= '0;
      busy <= 1'b0;
    end else begin
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      cpu_ack <= 1'b0;
      ld_ack <= 1'b0;
      if (!ld_lock) burst_cnt <= '0;
      case (state)
        IDLE: if (grant_valid) begin
          state <= ISSUE;
          busy <= 1'b1;
          owner <= grant_id;
          we_q <= sel_we;
          mem_addr <= grant_id ? ld_addr : cpu_addr;
          mem_wdata <= grant_id ? ld_wdata : cpu_wdata;
          mem_read <= ~sel_we;
          mem_write <= sel_we;
          burst_cnt <= (!ld_lock || !grant_id) ? '0 : burst_cnt + BW'(burst_cnt < BW'(MAX_BURST));
        end
        ISSUE: begin
          state <= WAIT;
          lat_cnt <= LW'(READ_LAT - 1);
        end
        WAIT: if (lat_cnt == '0) begin
          state <= DONE;
          cpu_ack <= ~owner;
          ld_ack <= owner;
          if (owner) ld_rdata <= mem_rdata;
          else cpu_rdata <= mem_rdata;
        end else lat_cnt <= lat_cnt - 1'b1;
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level model plus directed checks for the arbiter
module tb_mem_port_arbiter;
  localparam int L = 1;
  localparam int MB = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0, ld_lock = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, ld_addr = 0, ld_wdata = 0;
  logic cpu_ack, cpu_stall, ld_ack, mem_write, mem_read, busy, owner;
  logic [15:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
  logic c3_req = 0;
  logic [15:0] c3_addr = 0;
  logic c3_ack, c3_stall, l3_ack, m3_write, m3_read, b3, o3;
  logic [15:0] c3_rdata, l3_rdata, m3_addr, m3_wdata, m3_rdata;
  int n_cmp = 0, n_err = 0;
  int grants[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.READ_LAT(L), .MAX_BURST(MB)) u_dut (
    .clock(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.READ_LAT(3), .MAX_BURST(MB)) u_dut3 (
    .clock(clk), .rst(rst),
    .cpu_req(c3_req), .cpu_we(1'b0), .cpu_addr(c3_addr), .cpu_wdata(16'h0),
    .cpu_ack(c3_ack), .cpu_rdata(c3_rdata), .cpu_stall(c3_stall),
    .ld_req(1'b0), .ld_we(1'b0), .ld_lock(1'b0), .ld_addr(16'h0), .ld_wdata(16'h0),
    .ld_ack(l3_ack), .ld_rdata(l3_rdata),
    .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_write(m3_write), .mem_read(m3_read),
    .mem_rdata(m3_rdata), .busy(b3), .owner(o3)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {8'hA5, a};
  endfunction

  // memories: read data appears for exactly one cycle, READ_LAT cycles after the read strobe
  logic [15:0] mem [256];
  logic [15:0] pipe [L];
  bit loaded = 0;
  logic [15:0] pipe3 [3];
  assign mem_rdata = pipe[L-1];
  assign m3_rdata = pipe3[2];
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      loaded <= 1;
    end else if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    pipe[0] <= mem_read ? mem[mem_addr[7:0]] : 16'h0;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    pipe3[0] <= m3_read ? init_val(m3_addr[7:0]) : 16'h0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  // transaction-level model: grant at cycle 0, strobe at 1, ack at 2+L, back to idle after
  logic [15:0] gmem [256];
  bit g_loaded = 0, m_ok = 0, m_act = 0, m_we = 0, m_who = 0, m_owner = 1;
  int m_k = 0, m_burst = 0;
  logic [15:0] m_addr = 0, m_wd = 0, m_crd = 0, m_lrd = 0;
  always @(posedge clk) begin
    if (!g_loaded) begin
      for (int i = 0; i < 256; i++) gmem[i] = init_val(8'(i));
      g_loaded = 1;
    end
    if (m_act && m_k == 1 && m_we) gmem[m_addr[7:0]] = m_wd;
    if (rst) begin
      m_ok = 1; m_act = 0; m_k = 0; m_owner = 1; m_burst = 0;
      m_crd = 0; m_lrd = 0; m_addr = 0; m_wd = 0;
    end else begin
      if (!ld_lock) m_burst = 0;
      if (m_act && m_k == 2 + L) begin
        m_act = 0; m_k = 0;
      end else if (m_act) begin
        m_k++;
        if (m_k == 2 + L) begin
          if (m_who) m_lrd = m_we ? 16'h0 : gmem[m_addr[7:0]];
          else m_crd = m_we ? 16'h0 : gmem[m_addr[7:0]];
        end
      end else if (cpu_req || ld_req) begin
        if (!(cpu_req && ld_req)) m_who = ld_req;
        else if (m_owner && ld_lock && m_burst < MB) m_who = 1;
        else m_who = !m_owner;
        if (m_who && ld_lock) m_burst++;
        if (!m_who) m_burst = 0;
        m_owner = m_who; m_act = 1; m_k = 1;
        m_we = m_who ? ld_we : cpu_we;
        m_addr = m_who ? ld_addr : cpu_addr;
        m_wd = m_who ? ld_wdata : cpu_wdata;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // per-cycle comparison of every arbiter output against the model
  always @(posedge clk) begin
    #1;
    if (m_ok) begin
      chk("busy", 32'(busy), 32'(m_act));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("mem_read", 32'(mem_read), 32'(m_act && m_k == 1 && !m_we));
      chk("mem_write", 32'(mem_write), 32'(m_act && m_k == 1 && m_we));
      chk("cpu_ack", 32'(cpu_ack), 32'(m_act && m_k == 2 + L && !m_who));
      chk("ld_ack", 32'(ld_ack), 32'(m_act && m_k == 2 + L && m_who));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_crd));
      chk("ld_rdata", 32'(ld_rdata), 32'(m_lrd));
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !(m_act && m_k == 2 + L && !m_who)));
      if (m_act && m_k == 1) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
      end
    end
    if (cpu_ack) grants.push_back(0);
    if (ld_ack) grants.push_back(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit who, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(who ? ld_ack : cpu_ack) && n < 30);
    chk("ack_seen", 32'(who ? ld_ack : cpu_ack), 32'd1);
  endtask

  task automatic txn(input bit who, input bit we, input logic [15:0] a, input logic [15:0] d);
    int n;
    @(negedge clk);
    if (who) begin ld_req = 1; ld_we = we; ld_addr = a; ld_wdata = d; end
    else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    wait_ack(who, n);
    chk("latency", 32'(n), 32'(2 + L));
    @(negedge clk);
    if (who) ld_req = 0; else cpu_req = 0;
  endtask

  task automatic do_reset;
    @(negedge clk); rst = 1;
    tick(); tick();
    @(negedge clk); rst = 0;
  endtask

  task automatic both_until(input int cnt);
    int c;
    grants.delete();
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    ld_req = 1; ld_we = 0; ld_addr = 16'h0004;
    c = 0;
    while (grants.size() < cnt && c < 200) begin
      @(negedge clk);
      c++;
    end
    cpu_req = 0; ld_req = 0;
    chk("grant_count", 32'(grants.size() >= cnt), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 1);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_ld_ack", 32'(ld_ack), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    #1 chk("t0_stall", 32'(cpu_stall), 1);
    tick();
    chk("t1_mem_read", 32'(mem_read), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
    chk("t1_stall", 32'(cpu_stall), 1);
    tick();
    chk("t2_ack", 32'(cpu_ack), 0);
    chk("t2_stall", 32'(cpu_stall), 1);
    tick();
    chk("t3_ack", 32'(cpu_ack), 1);
    chk("t3_rdata", 32'(cpu_rdata), 32'hBEEF);
    chk("t3_stall", 32'(cpu_stall), 0);
    @(negedge clk); cpu_req = 0;
    txn(1, 1, 16'h0004, 16'h1234);
    txn(0, 0, 16'h0004, 16'h0);
    chk("rd_after_wr", 32'(cpu_rdata), 32'h1234);
    do_reset();
    both_until(4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("rr_order", 32'(grants[i]), 32'(i % 2));
    chk("rr_ld_rdata", 32'(ld_rdata), 32'h1234);
    chk("rr_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    do_reset();
    @(negedge clk); ld_lock = 1;
    both_until(18);
    for (int i = 0; i < 18 && i < grants.size(); i++)
      chk("burst_order", 32'(grants[i]), 32'((i == 8 || i == 17) ? 0 : 1));
    @(negedge clk); ld_lock = 0;
    tick();
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick(); tick();
    @(negedge clk); rst = 1;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ack", 32'(cpu_ack), 0);
    chk("abort_owner", 32'(owner), 1);
    @(negedge clk); rst = 0;
    wait_ack(0, n);
    chk("reissue_lat", 32'(n), 32'(2 + L));
    chk("reissue_rdata", 32'(cpu_rdata), 32'hBEEF);
    @(negedge clk); cpu_req = 0;
    @(negedge clk);
    c3_req = 1; c3_addr = 16'h0010;
    tick();
    chk("l3_strobe", 32'(m3_read), 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("l3_no_ack", 32'(c3_ack), 0);
      chk("l3_rdata_pulse", 32'(m3_rdata), 32'(i == 4 ? 16'hBEEF : 16'h0));
    end
    tick();
    chk("l3_ack", 32'(c3_ack), 1);
    chk("l3_rdata", 32'(c3_rdata), 32'hBEEF);
    @(negedge clk); c3_req = 0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
